multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the multi-cycle MIPS datapath (shared ALU, single unified memory, IR, PC).
- Replaces the single-cycle decoder when the core is built multi-cycle.
- Decodes OPcode from the IR and drives every datapath enable and mux select, one state per cycle.
- Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of state register and state_o debug port (min 4).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- OPcode  in  6  instruction[31:26] from IR, stable from DECODE onward
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (beq)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  write-back select: 0=ALUOut, 1=MDR
- RegDst  out  1  dest reg: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- ALUop  out  2  00=add, 01=sub, 10=funct
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state_o  out  STATE_W  current state encoding

Behaviour:
- Reset (async) forces IDLE. IDLE drives all outputs 0. Reset asserted mid-instruction aborts it immediately with no pending write.
- Unlisted outputs are 0 in every state.
- State encodings and sequencing (next state on clk edge):
  - IDLE=0 -> FETCH unconditionally.
  - FETCH=1: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
    - IRWrite=PCWrite=mem_ready (Mealy).
    - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
  - DECODE=2: ALUSrcA=0, ALUSrcB=11, ALUop=00. Next state by OPcode:
    - 100011/101011 -> MEMADR
    - 000000 -> EXEC
    - 001000/001001 -> ADDIEX
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - other -> FETCH, with illegal_op=1 and instr_done=1.
  - MEMADR=3: ALUSrcA=1, ALUSrcB=10, ALUop=00 -> MEMRD if lw, MEMWR if sw.
  - MEMRD=4: MemRead=1, IorD=1. Hold until mem_ready -> MEMWB.
  - MEMWB=5: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR=6: MemWrite=1, IorD=1. Hold until mem_ready, then -> FETCH with instr_done=1 in the ready cycle.
  - EXEC=7: ALUSrcA=1, ALUSrcB=00, ALUop=10 -> ALUWB.
  - ALUWB=8: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - ADDIEX=9: ALUSrcA=1, ALUSrcB=10, ALUop=00 -> ADDIWB.
  - ADDIWB=10: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - BRANCH=11: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP=12: PCWrite=1, PCSource=10 -> FETCH.
  - Unused encodings -> IDLE on the next edge, outputs 0.
- instr_done=1 in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, in the MEMWR ready cycle, and in DECODE for an illegal opcode.
- Cycle counts with mem_ready held high (FETCH through last state):
  - lw 5
  - sw, R-type, addi/addiu 4
  - beq, j 3
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemRead and MemWrite are never both 1. IRWrite is only asserted in FETCH.

Optional Feature:
- Macro INSTR_COUNT_EN.
- Defined: adds output instr_count (32 bits).
  - Reset to 0, increments on every clk edge where instr_done=1.
  - Wraps from 0xFFFFFFFF to 0.
  - Illegal opcodes are counted.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Assert reset for 3 cycles, release with mem_ready=1 -> state_o 0 then 1; all outputs 0 during reset and IDLE.
- lw (OPcode=100011), mem_ready=1 -> states 1,2,3,4,5,1; RegWrite=1 and MemtoReg=1 only in state 5; instr_done pulses once.
- sw with mem_ready=0 for 2 cycles in MEMWR -> MemWrite=1 and IorD=1 held for 3 cycles, then FETCH; RegWrite never 1.
- R-type, beq, j, addi back-to-back -> sequences 1,2,7,8 / 1,2,11 / 1,2,12 / 1,2,9,10 with the ALUop/PCSource values specified; instr_count=4 with INSTR_COUNT_EN defined.
- OPcode=111111 in DECODE -> illegal_op=1 and instr_done=1 for one cycle, next state FETCH, no write enable asserted.
- Reset asserted while in MEMRD -> outputs 0 in the same cycle (asynchronous), state_o=0; after release, FETCH restarts cleanly.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle MIPS datapath: one state per cycle, stalls on mem_ready.
// Optional INSTR_COUNT_EN adds a 32-bit retired-instruction counter output (instr_count).
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OPcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUop,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic               illegal_op,
`ifdef INSTR_COUNT_EN
  output logic [31:0]        instr_count,
`endif
  output logic [STATE_W-1:0] state_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = STATE_W'(0),
    S_FETCH  = STATE_W'(1),
    S_DECODE = STATE_W'(2),
    S_MEMADR = STATE_W'(3),
    S_MEMRD  = STATE_W'(4),
    S_MEMWB  = STATE_W'(5),
    S_MEMWR  = STATE_W'(6),
    S_EXEC   = STATE_W'(7),
    S_ALUWB  = STATE_W'(8),
    S_ADDIEX = STATE_W'(9),
    S_ADDIWB = STATE_W'(10),
    S_BRANCH = STATE_W'(11),
    S_JUMP   = STATE_W'(12)
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OPcode)
          OP_LW, OP_SW:       state_d = S_MEMADR;
          OP_RTYPE:           state_d = S_EXEC;
          OP_ADDI, OP_ADDIU:  state_d = S_ADDIEX;
          OP_BEQ:             state_d = S_BRANCH;
          OP_J:               state_d = S_JUMP;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (OPcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // FETCH handshake, MEMWR completion and illegal-opcode retirement are Mealy on inputs.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OPcode)
          OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_ADDIU, OP_BEQ, OP_J: ;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

`ifdef INSTR_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           count_q <= 32'd0;
    else if (instr_done) count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`endif

endmodule
